// File: rtl/mmio_defs.sv
`default_nettype none
// ============================================================================
// Module   : mmio_defs (package)
// Purpose  : Register offsets and RX_STATUS bit layout of the MMIO hub.
//            Shared between the RTL and software-side tests.
// Revision : 1.0 - initial release
// ============================================================================
package mmio_defs;

  // Word offsets inside the 16-word MMIO window (address bits [3:0])
  localparam logic [3:0] OFF_BTN_STATE = 4'd0;
  localparam logic [3:0] OFF_BTN_EDGE  = 4'd1;
  localparam logic [3:0] OFF_RX_STATUS = 4'd2;
  localparam logic [3:0] OFF_RX_DATA   = 4'd3;
  localparam logic [3:0] OFF_GPIO      = 4'd4;
  localparam logic [3:0] OFF_TIMER     = 4'd5;

  // RX_STATUS bit positions
  localparam int RXS_NOT_EMPTY = 0;
  localparam int RXS_FULL      = 1;
  localparam int RXS_OVERFLOW  = 2;
  localparam int RXS_COUNT_LSB = 8;
  localparam int RXS_COUNT_MSB = 15;

  // Assemble the RX_STATUS word from its fields
  function automatic logic [31:0] rx_status_word(input logic       not_empty,
                                                 input logic       full,
                                                 input logic       overflow,
                                                 input logic [7:0] count);
    logic [31:0] w;
    w                              = '0;
    w[RXS_NOT_EMPTY]               = not_empty;
    w[RXS_FULL]                    = full;
    w[RXS_OVERFLOW]                = overflow;
    w[RXS_COUNT_MSB:RXS_COUNT_LSB] = count;
    return w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo
// Purpose  : Single-clock FIFO with first-word fall-through output. A push
//            while full is accepted only when a pop happens in the same cycle.
// Revision : 1.0 - initial release
// ============================================================================
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (PW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr];

  // Storage array; no reset needed since count gates visibility
  always_ff @(posedge clock) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointers wrap naturally (DEPTH is a power of two); count tracks occupancy
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/mmio_hub.sv
`default_nettype none
// ============================================================================
// Module   : mmio_hub
// Purpose  : Memory-mapped peripheral hub between the CPU data port and data
//            RAM. A 16-word window holds button, UART RX FIFO, GPIO and timer
//            registers; every other address passes through to RAM.
//            Define MMIO_HUB_TIMER_EN to build the TIMER register; without
//            it offset 5 reads 0 and ignores writes.
// Revision : 1.0 - initial release
// ============================================================================
module mmio_hub
  import mmio_defs::*;
#(
  parameter int                    ADDR_WIDTH = 12,
  parameter logic [ADDR_WIDTH-1:0] MMIO_BASE  = 12'hF00,
  parameter int                    NUM_BTN    = 5,
  parameter int                    FIFO_DEPTH = 16,
  parameter int                    GPIO_WIDTH = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [31:0]           wdata,
  input  logic                  wen,
  input  logic                  ren,
  output logic [31:0]           rdata,
  input  logic [31:0]           ram_rdata,
  output logic                  ram_wen,
  input  logic [NUM_BTN-1:0]    btn,
  input  logic                  rx_valid,
  input  logic [7:0]            rx_byte,
  output logic [GPIO_WIDTH-1:0] gpio_out,
  output logic                  rx_overflow
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  // ---------------------------------------------------------------- decode
  logic       is_mmio;
  logic [3:0] offset;
  logic       mmio_wr;

  assign is_mmio = (addr[ADDR_WIDTH-1:4] == MMIO_BASE[ADDR_WIDTH-1:4]);
  assign offset  = addr[3:0];
  assign ram_wen = wen & ~is_mmio;
  assign mmio_wr = wen & is_mmio;

  // --------------------------------------------------------------- buttons
  logic [NUM_BTN-1:0] btn_s1;
  logic [NUM_BTN-1:0] btn_s2;
  logic [NUM_BTN-1:0] btn_prev;
  logic [NUM_BTN-1:0] btn_rise;
  logic [NUM_BTN-1:0] btn_edge;
  logic [NUM_BTN-1:0] btn_clr;

  assign btn_rise = btn_s2 & ~btn_prev;
  assign btn_clr  = (mmio_wr && offset == OFF_BTN_EDGE) ? wdata[NUM_BTN-1:0] : '0;

  // Two-flop synchroniser, edge detector, and sticky edge bits (set beats clear)
  always_ff @(posedge clock) begin
    if (reset) begin
      btn_s1   <= '0;
      btn_s2   <= '0;
      btn_prev <= '0;
      btn_edge <= '0;
    end else begin
      btn_s1   <= btn;
      btn_s2   <= btn_s1;
      btn_prev <= btn_s2;
      btn_edge <= (btn_edge & ~btn_clr) | btn_rise;
    end
  end

  // --------------------------------------------------------------- RX FIFO
  logic          fifo_push;
  logic          fifo_pop;
  logic [7:0]    fifo_dout;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;
  logic          ovf_clr;

  assign fifo_pop  = ren & is_mmio & (offset == OFF_RX_DATA) & ~fifo_empty;
  assign fifo_push = rx_valid & (~fifo_full | fifo_pop);
  assign ovf_clr   = mmio_wr & (offset == OFF_RX_STATUS) & wdata[RXS_OVERFLOW];

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_rx_fifo (
    .clock (clock),
    .reset (reset),
    .push  (fifo_push),
    .din   (rx_byte),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Sticky overflow: a byte arriving into a full FIFO with no pop is dropped
  always_ff @(posedge clock) begin
    if (reset) begin
      rx_overflow <= 1'b0;
    end else begin
      rx_overflow <= (rx_overflow & ~ovf_clr) | (rx_valid & fifo_full & ~fifo_pop);
    end
  end

  // ------------------------------------------------------------------ GPIO
  // GPIO output register
  always_ff @(posedge clock) begin
    if (reset) begin
      gpio_out <= '0;
    end else if (mmio_wr && offset == OFF_GPIO) begin
      gpio_out <= wdata[GPIO_WIDTH-1:0];
    end
  end

  // ----------------------------------------------------------------- TIMER
  logic [31:0] timer_val;

`ifdef MMIO_HUB_TIMER_EN
  logic [31:0] timer_q;

  // Free-running counter; a write counts as that cycle's tick, so the
  // value seen by a load in the next cycle is wdata+1
  always_ff @(posedge clock) begin
    if (reset) begin
      timer_q <= '0;
    end else if (mmio_wr && offset == OFF_TIMER) begin
      timer_q <= wdata + 32'd1;
    end else begin
      timer_q <= timer_q + 32'd1;
    end
  end

  assign timer_val = timer_q;
`else
  assign timer_val = '0;
`endif

  // ------------------------------------------------------------- read path
  logic [31:0] mmio_rd_data;
  logic [7:0]  count8;
  logic        sel_q;
  logic [31:0] mmio_q;

  // Count field is 8 bits wide; a full 256-deep FIFO wraps to 0 here
  assign count8 = 8'(fifo_count);

  // MMIO register read mux
  always_comb begin
    mmio_rd_data = '0;
    case (offset)
      OFF_BTN_STATE: mmio_rd_data = 32'(btn_s2);
      OFF_BTN_EDGE:  mmio_rd_data = 32'(btn_edge);
      OFF_RX_STATUS: mmio_rd_data = rx_status_word(~fifo_empty, fifo_full,
                                                   rx_overflow, count8);
      OFF_RX_DATA:   mmio_rd_data = fifo_empty ? 32'd0 : 32'(fifo_dout);
      OFF_GPIO:      mmio_rd_data = 32'(gpio_out);
      OFF_TIMER:     mmio_rd_data = timer_val;
      default:       mmio_rd_data = '0;
    endcase
  end

  // Register the MMIO read to match RAM's one-cycle synchronous read
  always_ff @(posedge clock) begin
    if (reset) begin
      sel_q  <= 1'b0;
      mmio_q <= '0;
    end else begin
      sel_q  <= is_mmio;
      mmio_q <= mmio_rd_data;
    end
  end

  assign rdata = sel_q ? mmio_q : ram_rdata;

  // Upper store-data bits are not needed by every register
  logic unused_ok;
  assign unused_ok = &{1'b0, wdata};

endmodule
`default_nettype wire

// File: tb/tb_mmio_hub.sv
`default_nettype none
// ============================================================================
// Module   : tb_mmio_hub
// Purpose  : Directed self-checking bench for mmio_hub with a load-data
//            scoreboard and a behavioural one-cycle synchronous RAM.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mmio_hub;

  logic        clock;
  logic        reset;
  logic [11:0] addr;
  logic [31:0] wdata;
  logic        wen;
  logic        ren;
  logic [31:0] rdata;
  logic [31:0] ram_rdata;
  logic        ram_wen;
  logic [4:0]  btn;
  logic        rx_valid;
  logic [7:0]  rx_byte;
  logic [15:0] gpio_out;
  logic        rx_overflow;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] exp_q[$];
  string       tag_q[$];
  logic        ren_d = 1'b0;

  logic [31:0] ram [0:4095];

  mmio_hub dut (
    .clock       (clock),
    .reset       (reset),
    .addr        (addr),
    .wdata       (wdata),
    .wen         (wen),
    .ren         (ren),
    .rdata       (rdata),
    .ram_rdata   (ram_rdata),
    .ram_wen     (ram_wen),
    .btn         (btn),
    .rx_valid    (rx_valid),
    .rx_byte     (rx_byte),
    .gpio_out    (gpio_out),
    .rx_overflow (rx_overflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Behavioural data RAM: one-cycle synchronous read
  initial begin
    for (int i = 0; i < 4096; i++) ram[i] = 32'd0;
    ram_rdata = 32'd0;
  end
  always @(posedge clock) begin
    if (ram_wen) ram[addr] <= wdata;
    ram_rdata <= ram[addr];
  end

  always @(posedge clock) ren_d <= ren;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Load data appears one cycle after ren; compare against scoreboard head
  always @(negedge clock) begin
    if (ren_d) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $error("FAIL sb_underflow: observed load %h expected none", rdata);
      end else begin
        logic [31:0] e;
        string       t;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        check(t, rdata, e);
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic store(input logic [11:0] a, input logic [31:0] d,
                       input logic exp_wen, input string tag);
    addr  = a;
    wdata = d;
    wen   = 1'b1;
    #1;
    check(tag, 32'(ram_wen), 32'(exp_wen));
    tick();
    wen = 1'b0;
  endtask

  task automatic load(input logic [11:0] a, input logic [31:0] e, input string tag);
    addr = a;
    ren  = 1'b1;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    tick();
    ren = 1'b0;
  endtask

  task automatic push_rx(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_byte  = b;
    tick();
    rx_valid = 1'b0;
  endtask

  initial begin
    reset    = 1'b1;
    addr     = '0;
    wdata    = '0;
    wen      = 1'b0;
    ren      = 1'b0;
    btn      = '0;
    rx_valid = 1'b0;
    rx_byte  = '0;
    tick();
    tick();

    // Stores during reset: RAM sees them, MMIO does not
    store(12'h020, 32'h000055AA, 1'b1, "rst_ram_wen");
    store(12'hF04, 32'h0000BEEF, 1'b0, "rst_mmio_wen");
    addr  = 12'hF04;
    reset = 1'b0;
    #1;
    check("rst_gpio", 32'(gpio_out), 32'h0);
    check("rst_ovf", 32'(rx_overflow), 32'h0);
    check("rst_rdata", rdata, 32'h0);

    // RAM pass-through
    store(12'h010, 32'hDEADBEEF, 1'b1, "ram_wen_010");
    load(12'h010, 32'hDEADBEEF, "ram_ld_010");
    load(12'h020, 32'h000055AA, "ram_ld_020");

    // GPIO isolation
    store(12'hF04, 32'h00001234, 1'b0, "gpio_wen");
    check("gpio_out", 32'(gpio_out), 32'h00001234);
    load(12'hF04, 32'h00001234, "gpio_ld");

    // Unmapped offset
    store(12'hF06, 32'hFFFFFFFF, 1'b0, "off6_wen");
    load(12'hF06, 32'h0, "off6_ld");

    // Button edge latency
    load(12'hF00, 32'h0, "btn_state0");
    btn = 5'b00100;
    tick();
    tick();
    load(12'hF01, 32'h0, "btn_edge_early");
    load(12'hF01, 32'h4, "btn_edge_set");
    load(12'hF00, 32'h4, "btn_state1");

    // W1C colliding with a new edge: set wins
    btn = 5'b00000;
    tick();
    tick();
    tick();
    btn = 5'b00100;
    tick();
    tick();
    store(12'hF01, 32'h4, 1'b0, "btn_w1c_wen");
    load(12'hF01, 32'h4, "btn_set_wins");
    store(12'hF01, 32'h4, 1'b0, "btn_w1c2_wen");
    load(12'hF01, 32'h0, "btn_cleared");

    // FIFO ordering
    push_rx(8'hA1);
    push_rx(8'hB2);
    load(12'hF02, 32'h00000201, "rx_stat2");
    load(12'hF03, 32'h000000A1, "rx_pop_a1");
    load(12'hF03, 32'h000000B2, "rx_pop_b2");
    load(12'hF03, 32'h0, "rx_pop_empty");
    load(12'hF02, 32'h0, "rx_stat0");

    // Overflow
    for (int i = 0; i < 16; i++) push_rx(8'h10 + 8'(i));
    push_rx(8'hEE);
    check("rx_ovf_pin", 32'(rx_overflow), 32'h1);
    load(12'hF02, 32'h00001007, "rx_stat_full_ovf");
    store(12'hF02, 32'h4, 1'b0, "rx_w1c_wen");
    check("rx_ovf_clr", 32'(rx_overflow), 32'h0);
    load(12'hF02, 32'h00001003, "rx_stat_full");

    // Push and pop together while full
    rx_valid = 1'b1;
    rx_byte  = 8'h77;
    load(12'hF03, 32'h00000010, "rx_pp_head");
    rx_valid = 1'b0;
    load(12'hF02, 32'h00001003, "rx_pp_stat");
    check("rx_pp_ovf", 32'(rx_overflow), 32'h0);
    for (int i = 1; i < 16; i++) load(12'hF03, 32'h10 + 32'(i), "rx_drain");
    load(12'hF03, 32'h00000077, "rx_drain_last");
    load(12'hF03, 32'h0, "rx_drain_empty");
    load(12'hF02, 32'h0, "rx_drain_stat");

    // Timer load and wrap
`ifdef MMIO_HUB_TIMER_EN
    store(12'hF05, 32'hFFFFFFFE, 1'b0, "tmr_wen");
    load(12'hF05, 32'hFFFFFFFF, "tmr_next");
    load(12'hF05, 32'h00000000, "tmr_wrap");
`else
    store(12'hF05, 32'hFFFFFFFE, 1'b0, "tmr_wen");
    load(12'hF05, 32'h0, "tmr_off0");
    load(12'hF05, 32'h0, "tmr_off1");
`endif

    // Reset in the middle of a FIFO fill
    btn = 5'b00000;
    push_rx(8'h01);
    push_rx(8'h02);
    push_rx(8'h03);
    store(12'hF04, 32'h0000ABCD, 1'b0, "gpio2_wen");
    check("gpio_out2", 32'(gpio_out), 32'h0000ABCD);
    reset    = 1'b1;
    rx_valid = 1'b1;
    rx_byte  = 8'h55;
    tick();
    reset    = 1'b0;
    rx_valid = 1'b0;
    check("mid_rst_gpio", 32'(gpio_out), 32'h0);
    check("mid_rst_ovf", 32'(rx_overflow), 32'h0);
`ifdef MMIO_HUB_TIMER_EN
    load(12'hF05, 32'h0, "mid_rst_tmr0");
    load(12'hF05, 32'h1, "mid_rst_tmr1");
`else
    load(12'hF05, 32'h0, "mid_rst_tmr0");
    load(12'hF05, 32'h0, "mid_rst_tmr1");
`endif
    load(12'hF02, 32'h0, "mid_rst_stat");
    load(12'hF03, 32'h0, "mid_rst_data");
    load(12'hF01, 32'h0, "mid_rst_edge");
    load(12'hF04, 32'h0, "mid_rst_gpio_ld");

    tick();
    tick();
    check("sb_drain", 32'(exp_q.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
